// File: rtl/inner_mem_pkg.sv
// Shared types and helpers for the inner memory controller.
// Optional feature macro: INNER_MEM_SIGN_EXT_EN (sign-extend byte loads).
package inner_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RMW_WR
   } mem_state_e;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;
   localparam logic RW_WORD   = 1'b0;
   localparam logic RW_BYTE   = 1'b1;

   // Little-endian lane pick: lane 0 is bits 7:0.
   function automatic logic [7:0] byte_lane_extract(input logic [31:0] word,
                                                    input logic [1:0]  lane);
      logic [7:0] lane_byte;
      case (lane)
         2'd0:    lane_byte = word[7:0];
         2'd1:    lane_byte = word[15:8];
         2'd2:    lane_byte = word[23:16];
         default: lane_byte = word[31:24];
      endcase
      return lane_byte;
   endfunction

endpackage

// File: rtl/inner_memory_if.sv
// CPU-side bus between the MEM stage and the inner memory controller.
interface inner_memory_if;

   logic        MemRW;
   logic        RWType;
   logic [31:0] addr_out;
   logic [31:0] data_out;
   logic [31:0] data_in;

   // MEM stage side
   modport master (
      output MemRW, RWType, addr_out, data_out,
      input  data_in
   );

   // Memory controller side
   modport slave (
      input  MemRW, RWType, addr_out, data_out,
      output data_in
   );

   // Same view as slave, under the name the controller uses
   modport controller (
      input  MemRW, RWType, addr_out, data_out,
      output data_in
   );

endinterface

// File: rtl/byte_lane_merge.sv
// Replaces one byte lane of a word; used to build read-modify-write data.
module byte_lane_merge (
   input  logic [31:0] word,
   input  logic [7:0]  wr_byte,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   // Copy the word, then overwrite the addressed lane
   always_comb begin
      merged = word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (lane == i[1:0]) begin
            merged[i*8 +: 8] = wr_byte;
         end
      end
   end

endmodule

// File: rtl/inner_memory_ctrl.sv
// Inner memory controller: word/byte loads and stores onto a word-wide
// single-port synchronous RAM (1-cycle read latency). Byte stores use
// read-modify-write; loads stall one cycle.
// Optional feature macro: INNER_MEM_SIGN_EXT_EN (byte loads sign-extended).
module inner_memory_ctrl
   import inner_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   inner_memory_if.controller   mem,
   input  logic                 mem_req,
   output logic                 stall,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [31:0]          ram_wdata,
   input  logic [31:0]          ram_rdata
);

   mem_state_e        state;
   logic [ADDR_W+1:0] addr_q;
   logic [7:0]        wdata_q;
   logic              type_q;
   logic [31:0]       rdata_q;
   logic [31:0]       rd_fmt;
   logic [31:0]       merged;

   // Address bits above the RAM range wrap and are deliberately dropped
   logic unused_addr_hi;
   assign unused_addr_hi = ^mem.addr_out[31:ADDR_W+2];

   function automatic logic [31:0] format_load(input logic [31:0] word,
                                               input logic        rw_type,
                                               input logic [1:0]  lane);
      logic [7:0]  lane_byte;
      logic [31:0] result;
      lane_byte = byte_lane_extract(word, lane);
      if (rw_type == RW_BYTE) begin
`ifdef INNER_MEM_SIGN_EXT_EN
         result = {{24{lane_byte[7]}}, lane_byte};
`else
         result = {24'b0, lane_byte};
`endif
      end else begin
         result = word;
      end
      return result;
   endfunction

   assign rd_fmt = format_load(ram_rdata, type_q, addr_q[1:0]);

   byte_lane_merge u_merge (
      .word    (ram_rdata),
      .wr_byte (wdata_q),
      .lane    (addr_q[1:0]),
      .merged  (merged)
   );

   // Control FSM: latch the request on accept, then finish load or RMW
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         type_q  <= RW_WORD;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  addr_q  <= mem.addr_out[ADDR_W+1:0];
                  wdata_q <= mem.data_out[7:0];
                  type_q  <= mem.RWType;
                  if (mem.MemRW == MEM_READ) begin
                     state <= RD_WAIT;
                  end else if (mem.RWType == RW_BYTE) begin
                     state <= RMW_WR;
                  end
               end
            end
            RD_WAIT: begin
               rdata_q <= rd_fmt;
               state   <= IDLE;
            end
            RMW_WR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // RAM strobes and stall are decoded from state and the live request so a
   // word store completes with no stall and a load/RMW stalls in the same
   // cycle it is presented; rst_n gating keeps reset values on the outputs
   // even if mem_req is high while reset is held.
   always_comb begin
      stall       = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      mem.data_in = rdata_q;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (mem_req) begin
                  ram_en   = 1'b1;
                  ram_addr = mem.addr_out[ADDR_W+1:2];
                  if (mem.MemRW == MEM_WRITE && mem.RWType == RW_WORD) begin
                     ram_we    = 1'b1;
                     ram_wdata = mem.data_out;
                  end else begin
                     stall = 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               mem.data_in = rd_fmt;
            end
            RMW_WR: begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = addr_q[ADDR_W+1:2];
               ram_wdata = merged;
            end
            default: begin
               stall = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inner_memory_ctrl.sv
// Self-checking bench for inner_memory_ctrl: directed scenarios plus random
// load/store traffic against a byte-array reference of memory.
// Honours INNER_MEM_SIGN_EXT_EN for byte-load expectations.
module tb_inner_memory_ctrl;
   import inner_mem_pkg::*;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mem_req;
   logic              stall;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   inner_memory_if mem_bus ();

   inner_memory_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem       (mem_bus),
      .mem_req   (mem_req),
      .stall     (stall),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, one cycle read latency
   logic [31:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Reference: memory as a flat byte array
   logic [7:0]  ref_bytes [4*DEPTH];
   logic [31:0] last_load;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic int unsigned ref_base(input logic [31:0] a);
      return ((a >> 2) % DEPTH) * 4;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int unsigned b;
      b = ref_base(a);
      return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
   endfunction

   function automatic logic [31:0] ref_load(input logic typ, input logic [31:0] a);
      logic [7:0] v;
      if (typ == RW_WORD) return ref_word(a);
      v = ref_bytes[ref_base(a) + a[1:0]];
`ifdef INNER_MEM_SIGN_EXT_EN
      return {{24{v[7]}}, v};
`else
      return {24'b0, v};
`endif
   endfunction

   task automatic ref_store(input logic typ, input logic [31:0] a, input logic [31:0] d);
      int unsigned b;
      b = ref_base(a);
      if (typ == RW_WORD) begin
         for (int k = 0; k < 4; k++) ref_bytes[b + k] = d[8*k +: 8];
      end else begin
         ref_bytes[b + a[1:0]] = d[7:0];
      end
   endtask

   // One MEM-stage operation, including its stall cycle when there is one
   task automatic do_op(input logic rw, input logic typ, input logic [31:0] a,
                        input logic [31:0] d);
      logic [31:0] exp;
      @(posedge clk); #1;
      mem_req          = 1'b1;
      mem_bus.MemRW    = rw;
      mem_bus.RWType   = typ;
      mem_bus.addr_out = a;
      mem_bus.data_out = d;
      #4;
      if (rw == MEM_WRITE && typ == RW_WORD) begin
         check("ww_stall", {31'b0, stall}, 32'd0);
         check("ww_we", {31'b0, ram_we}, 32'd1);
         check("ww_addr", {22'b0, ram_addr}, {22'b0, a[ADDR_W+1:2]});
         check("ww_wdata", ram_wdata, d);
         ref_store(typ, a, d);
      end else begin
         check("op_stall", {31'b0, stall}, 32'd1);
         check("op_en", {31'b0, ram_en}, 32'd1);
         check("op_we", {31'b0, ram_we}, 32'd0);
         check("op_addr", {22'b0, ram_addr}, {22'b0, a[ADDR_W+1:2]});
         exp = ref_load(typ, a);
         @(posedge clk); #1;
         // Inputs during the second cycle must be ignored
         mem_req          = 1'($urandom);
         mem_bus.MemRW    = 1'($urandom);
         mem_bus.RWType   = 1'($urandom);
         mem_bus.addr_out = $urandom;
         mem_bus.data_out = $urandom;
         #4;
         check("wait_stall", {31'b0, stall}, 32'd0);
         if (rw == MEM_READ) begin
            check("rd_data", mem_bus.data_in, exp);
            last_load = exp;
         end else begin
            ref_store(typ, a, d);
            check("rmw_we", {31'b0, ram_we}, 32'd1);
            check("rmw_addr", {22'b0, ram_addr}, {22'b0, a[ADDR_W+1:2]});
            check("rmw_wdata", ram_wdata, ref_word(a));
         end
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      mem_req        = 1'b0;
      mem_bus.MemRW  = 1'($urandom);
      mem_bus.RWType = 1'($urandom);
      #4;
      check("idle_en", {31'b0, ram_en}, 32'd0);
      check("idle_we", {31'b0, ram_we}, 32'd0);
      check("idle_stall", {31'b0, stall}, 32'd0);
      check("idle_hold", mem_bus.data_in, last_load);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stall"}, {31'b0, stall}, 32'd0);
      check({tag, "_en"}, {31'b0, ram_en}, 32'd0);
      check({tag, "_we"}, {31'b0, ram_we}, 32'd0);
      check({tag, "_addr"}, {22'b0, ram_addr}, 32'd0);
      check({tag, "_wdata"}, ram_wdata, 32'd0);
      check({tag, "_din"}, mem_bus.data_in, 32'd0);
   endtask

   logic [31:0] exp_b;
   logic [31:0] ra;
   int unsigned pick;

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] = '0;
      for (int i = 0; i < int'(4*DEPTH); i++) ref_bytes[i] = '0;
      ram_rdata        = '0;
      last_load        = '0;
      rst_n            = 1'b0;
      mem_req          = 1'b0;
      mem_bus.MemRW    = 1'b0;
      mem_bus.RWType   = 1'b0;
      mem_bus.addr_out = '0;
      mem_bus.data_out = '0;
      #1;
      check_reset_outputs("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Word write then word read, result held afterwards
      do_op(MEM_WRITE, RW_WORD, 32'h10, 32'hDEADBEEF);
      do_op(MEM_READ,  RW_WORD, 32'h10, 32'h0);
      idle_cycle();
      check("deadbeef", mem_bus.data_in, 32'hDEADBEEF);

      // Byte store into a known word
      do_op(MEM_WRITE, RW_WORD, 32'h20, 32'h11223344);
      do_op(MEM_WRITE, RW_BYTE, 32'h22, 32'h000000AA);
      idle_cycle();
      check("rmw_ram", ram_mem[8], 32'h11AA3344);
      do_op(MEM_READ, RW_WORD, 32'h20, 32'h0);

      // Byte load of a lane with bit 7 set
      do_op(MEM_WRITE, RW_WORD, 32'h20, 32'h80FF0000);
      do_op(MEM_READ,  RW_BYTE, 32'h23, 32'h0);
      idle_cycle();
`ifdef INNER_MEM_SIGN_EXT_EN
      exp_b = 32'hFFFFFF80;
`else
      exp_b = 32'h00000080;
`endif
      check("byte_rd", mem_bus.data_in, exp_b);

      // Back-to-back word stores, then a misaligned word load
      do_op(MEM_WRITE, RW_WORD, 32'h10, 32'hA0A0A0A0);
      do_op(MEM_WRITE, RW_WORD, 32'h14, 32'hB1B1B1B1);
      do_op(MEM_WRITE, RW_WORD, 32'h18, 32'hC2C2C2C2);
      do_op(MEM_WRITE, RW_WORD, 32'h1C, 32'hD3D3D3D3);
      do_op(MEM_READ,  RW_WORD, 32'h13, 32'h0);
      idle_cycle();
      check("misalign_rd", mem_bus.data_in, 32'hA0A0A0A0);

      // Address wrap above the RAM range
      do_op(MEM_WRITE, RW_WORD, 32'h1000, 32'h5A5AC3C3);
      do_op(MEM_READ,  RW_WORD, 32'h0, 32'h0);
      idle_cycle();

      // Reset in the middle of the RMW write cycle
      do_op(MEM_WRITE, RW_WORD, 32'h40, 32'h11223344);
      @(posedge clk); #1;
      mem_req          = 1'b1;
      mem_bus.MemRW    = MEM_WRITE;
      mem_bus.RWType   = RW_BYTE;
      mem_bus.addr_out = 32'h41;
      mem_bus.data_out = 32'h55;
      #4;
      check("rmwrst_stall", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      mem_req = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      last_load = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rmwrst_ram", ram_mem[16], 32'h11223344);
      do_op(MEM_READ, RW_WORD, 32'h40, 32'h0);
      idle_cycle();

      // Random traffic, biased towards a small address window for reuse
      for (int n = 0; n < 400; n++) begin
         ra   = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 63));
         pick = $urandom_range(0, 4);
         case (pick)
            0: do_op(MEM_WRITE, RW_WORD, ra, $urandom);
            1: do_op(MEM_WRITE, RW_BYTE, ra, $urandom);
            2: do_op(MEM_READ,  RW_WORD, ra, $urandom);
            3: do_op(MEM_READ,  RW_BYTE, ra, $urandom);
            default: idle_cycle();
         endcase
      end
      idle_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
